// File: rtl/adc_max10_scan_sequencer.sv
// Scan sequencer for the MAX10 modular ADC: walks an enabled-channel mask, issues one
// Avalon-ST command per channel, captures results into a 32-entry table and flags completion.
module adc_max10_scan_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             cfg_enable,
  input  logic [31:0]      cfg_mask,
  input  logic             cfg_continuous,
  input  logic             cfg_trig_en,
  input  logic             start,
  input  logic             irq_en,
  input  logic             irq_clear,
  input  logic             ADC_Trigger,
  output logic             ADC_C_Valid,
  output logic [4:0]       ADC_C_Channel,
  output logic             ADC_C_SOP,
  output logic             ADC_C_EOP,
  input  logic             ADC_C_Ready,
  input  logic             ADC_R_Valid,
  input  logic [4:0]       ADC_R_Channel,
  input  logic [11:0]      ADC_R_Data,
  input  logic [4:0]       rd_addr,
  output logic [15:0]      rd_data,
  output logic             busy,
  output logic [CNT_W-1:0] scan_count,
  output logic             err_timeout,
  output logic             err_chan,
  output logic             ADC_Interrupt
);

  typedef enum logic [2:0] {StIdle, StCmd, StWaitRsp, StNext, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      scan_mask_q, scan_mask_d;
  logic [4:0]       cur_ch_q, cur_ch_d;
  logic [9:0]       to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic             err_to_q, err_to_d;
  logic             err_chan_q, err_chan_d;
  logic             irq_q, irq_d;
  logic             trig_q;
  logic [31:0]      tbl_valid_q;
  logic [11:0]      tbl_data_q [32];
  logic [15:0]      rd_data_q;

  logic             start_evt;
  logic             rsp_match;
  logic             tbl_we;
  logic [31:0]      above_mask;
  logic [31:0]      remaining;

  function automatic logic [4:0] lowest_bit(input logic [31:0] m);
    logic [4:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) r = 5'(i);
    end
    return r;
  endfunction

  assign start_evt = start | (cfg_trig_en & ADC_Trigger & ~trig_q);
  assign rsp_match = (state_q == StWaitRsp) && ADC_R_Valid && (ADC_R_Channel == cur_ch_q);

  always_comb begin
    above_mask = '0;
    for (int i = 0; i < 32; i++) begin
      above_mask[i] = (i > int'(cur_ch_q));
    end
  end
  assign remaining = scan_mask_q & above_mask;

  always_comb begin
    state_d     = state_q;
    scan_mask_d = scan_mask_q;
    cur_ch_d    = cur_ch_q;
    to_cnt_d    = to_cnt_q;
    scan_cnt_d  = scan_cnt_q;
    err_to_d    = err_to_q;
    err_chan_d  = err_chan_q;
    irq_d       = irq_q;
    tbl_we      = 1'b0;

    // Clear first so that any set condition in the same cycle wins.
    if (irq_clear) begin
      err_to_d   = 1'b0;
      err_chan_d = 1'b0;
      irq_d      = 1'b0;
    end
    if (ADC_R_Valid && !rsp_match) err_chan_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start_evt && cfg_enable && (cfg_mask != '0)) begin
          scan_mask_d = cfg_mask;
          cur_ch_d    = lowest_bit(cfg_mask);
          state_d     = StCmd;
        end
      end
      StCmd: begin
        if (ADC_C_Ready) begin
          to_cnt_d = '0;
          state_d  = StWaitRsp;
        end
      end
      StWaitRsp: begin
        if (rsp_match) begin
          tbl_we  = 1'b1;
          state_d = StNext;
        end else if (to_cnt_q == 10'(TIMEOUT_CYCLES - 1)) begin
          err_to_d = 1'b1;
          state_d  = StNext;
        end else begin
          to_cnt_d = to_cnt_q + 10'd1;
        end
      end
      StNext: begin
        if (!cfg_enable) begin
          state_d = StIdle;
        end else if (remaining != '0) begin
          cur_ch_d = lowest_bit(remaining);
          state_d  = StCmd;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        if (irq_en) irq_d = 1'b1;
        state_d = StIdle;
        if (cfg_continuous && cfg_enable) begin
          scan_mask_d = cfg_mask;
          if (cfg_mask != '0) begin
            cur_ch_d = lowest_bit(cfg_mask);
            state_d  = StCmd;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= StIdle;
      scan_mask_q <= '0;
      cur_ch_q    <= '0;
      to_cnt_q    <= '0;
      scan_cnt_q  <= '0;
      err_to_q    <= 1'b0;
      err_chan_q  <= 1'b0;
      irq_q       <= 1'b0;
      trig_q      <= 1'b0;
      tbl_valid_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      scan_mask_q <= scan_mask_d;
      cur_ch_q    <= cur_ch_d;
      to_cnt_q    <= to_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      err_to_q    <= err_to_d;
      err_chan_q  <= err_chan_d;
      irq_q       <= irq_d;
      trig_q      <= ADC_Trigger;
      if (tbl_we) tbl_valid_q[cur_ch_q] <= 1'b1;
      // Invalid entries read as zero so stale samples never leak after a reset.
      rd_data_q   <= tbl_valid_q[rd_addr] ? {4'b1000, tbl_data_q[rd_addr]} : 16'h0000;
    end
  end

  always_ff @(posedge HCLK) begin
    if (tbl_we) tbl_data_q[cur_ch_q] <= ADC_R_Data;
  end

  assign ADC_C_Valid   = (state_q == StCmd);
  assign ADC_C_SOP     = ADC_C_Valid;
  assign ADC_C_EOP     = ADC_C_Valid;
  assign ADC_C_Channel = cur_ch_q;
  assign busy          = (state_q != StIdle);
  assign scan_count    = scan_cnt_q;
  assign err_timeout   = err_to_q;
  assign err_chan      = err_chan_q;
  assign ADC_Interrupt = irq_q;
  assign rd_data       = rd_data_q;

endmodule
